// File: rtl/alu_arb_pkg.sv
// Shared types for alu_arbiter: opcode set, FSM states, captured request record.
// No logic; combinational helpers only.
package alu_arb_pkg;

  localparam int ALU_DW = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    alu_op_e             op;
    logic [ALU_DW-1:0]   a;
    logic [ALU_DW-1:0]   b;
    logic                id;
  } alu_req_t;

  // Index of the single set bit of a 2-bit one-hot grant.
  function automatic logic gnt_idx(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant from valid and pointer, zero latency.
// Pointer moves to the losing side only when the caller reports an accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] vld,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = 2'b00;
    unique case (vld)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After serving requester 0 the pointer favours 1, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one registered 8-bit ALU; result 1 cycle after accept, >=3 cycles/op.
// Holds result until rsp_ready; rsp_c/rsp_z flag ports exist only with ALU_ARB_FLAGS_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW = ALU_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [2:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_y
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic          rsp_c,
  output logic          rsp_z
`endif
);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [1:0]    gnt;
  logic          req_hs;
  alu_req_t      req_q;
  alu_req_t      req_d;
  logic [DW-1:0] alu_y;
  logic [DW-1:0] rsp_y_q;
  logic [DW-1:0] rsp_y_d;
  logic          rsp_id_q;
  logic          rsp_id_d;

  assign req_hs = |req_ready;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld    (req_valid),
    .accept (req_hs),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_hs)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready = gnt;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Requests are snapshotted so requesters are free to move on after the accept edge.
  always_comb begin
    req_d = req_q;
    if (req_hs) begin
      req_d.id = gnt_idx(req_ready);
      if (gnt_idx(req_ready)) begin
        req_d.op = alu_op_e'(req1_op);
        req_d.a  = req1_a;
        req_d.b  = req1_b;
      end else begin
        req_d.op = alu_op_e'(req0_op);
        req_d.a  = req0_a;
        req_d.b  = req0_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  always_comb begin
    alu_y = '0;
    unique case (req_q.op)
      OP_ADD:  alu_y = req_q.a + req_q.b;
      OP_SUB:  alu_y = req_q.a - req_q.b;
      OP_AND:  alu_y = req_q.a & req_q.b;
      OP_OR:   alu_y = req_q.a | req_q.b;
      OP_XOR:  alu_y = req_q.a ^ req_q.b;
      OP_NOT:  alu_y = ~req_q.a;
      OP_SHL:  alu_y = {req_q.a[DW-2:0], 1'b0};
      OP_SHR:  alu_y = {1'b0, req_q.a[DW-1:1]};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    rsp_y_d  = rsp_y_q;
    rsp_id_d = rsp_id_q;
    if (state_q == ST_EXEC) begin
      rsp_y_d  = alu_y;
      rsp_id_d = req_q.id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y_q  <= '0;
      rsp_id_q <= 1'b0;
    end else begin
      rsp_y_q  <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_y  = rsp_y_q;
  assign rsp_id = rsp_id_q;

`ifdef ALU_ARB_FLAGS_EN
  logic alu_c;
  logic alu_z;
  logic rsp_c_q;
  logic rsp_c_d;
  logic rsp_z_q;
  logic rsp_z_d;

  // A wrapped add always lands below its first operand; SUB carry is the borrow.
  always_comb begin
    alu_c = 1'b0;
    unique case (req_q.op)
      OP_ADD:  alu_c = (alu_y < req_q.a);
      OP_SUB:  alu_c = (req_q.a < req_q.b);
      OP_SHL:  alu_c = req_q.a[DW-1];
      OP_SHR:  alu_c = req_q.a[0];
      default: alu_c = 1'b0;
    endcase
  end

  assign alu_z = (alu_y == '0);

  always_comb begin
    rsp_c_d = rsp_c_q;
    rsp_z_d = rsp_z_q;
    if (state_q == ST_EXEC) begin
      rsp_c_d = alu_c;
      rsp_z_d = alu_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_c_q <= 1'b0;
      rsp_z_q <= 1'b0;
    end else begin
      rsp_c_q <= rsp_c_d;
      rsp_z_q <= rsp_z_d;
    end
  end

  assign rsp_c = rsp_c_q;
  assign rsp_z = rsp_z_q;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DW, default 8, operand/result width in bits; only 8 is supported.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 req0_op / req1_op  input  3 each  ALU opcode per requester.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  8 each  operands per requester.
REQ-008 rsp_valid  output  1  result valid.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  index of requester the result belongs to.
REQ-011 rsp_y  output  8  result.
REQ-012 rsp_c, rsp_z  output  1 each  carry and zero flags; present only with ALU_ARB_FLAGS_EN.

Function
REQ-013 FSM states IDLE, EXEC, RESP; IDLE->EXEC on request handshake, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid && rsp_ready.
REQ-014 req_ready[i] high only in IDLE, only when req_valid[i] high and requester i holds the grant; combinational from valid and pointer.
REQ-015 Grant: only one valid -> that one; both valid -> requester named by round-robin pointer.
REQ-016 Pointer toggles to the non-granted requester on every accepted request; unchanged otherwise.
REQ-017 On handshake at edge k: opcode, operands, id captured into registers; requester may change inputs after edge k.
REQ-018 Result registered at edge k+1; rsp_valid high from edge k+1 until the edge where rsp_ready is sampled high.
REQ-019 rsp_id, rsp_y, flags stable while rsp_valid high and rsp_ready low.
REQ-020 Minimum 3 cycles per operation; no new request accepted in EXEC or RESP.
REQ-021 Opcodes: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 A<<1 (LSB 0), 111 A>>1 (MSB 0); all results truncated to 8 bits (wrap-around).
REQ-022 Carry: ADD = bit 8 of 9-bit sum; SUB = 1 when A<B (borrow); SHL = A[7]; SHR = A[0]; all others 0.
REQ-023 Zero: 1 when the 8-bit result is 0x00, for every opcode.
REQ-024 Requester dropping req_valid without handshake is legal; no state change.

Reset
REQ-025 rst_n low: state IDLE, pointer = requester 0, rsp_valid 0, rsp_id 0, rsp_y 0x00, rsp_c 0, rsp_z 0, immediately and independent of clk.
REQ-026 Reset during EXEC or RESP discards the operation; no response for it is ever produced.
REQ-027 First grant after rst_n release follows REQ-015 with pointer = 0.

Configuration
REQ-028 Macro ALU_ARB_FLAGS_EN defined: rsp_c and rsp_z ports and flag registers exist per REQ-022/023.
REQ-029 Macro ALU_ARB_FLAGS_EN undefined: rsp_c and rsp_z ports and flag logic absent; all other behaviour identical.

Structure
REQ-030 Shared package alu_arb_pkg holds: opcode enumeration (8 codes of REQ-021), FSM state type, DW constant.
REQ-031 One sub-module rr_arb2: 2-input round-robin arbiter (valid in, grant out, pointer update on accept); ALU decode stays inline.

Verification
REQ-032 Req0 only, op 000, A=0xF0, B=0x20 -> accept edge k, rsp at k+1: rsp_id 0, rsp_y 0x10, rsp_c 1, rsp_z 0.
REQ-033 Both valid continuously after reset, rsp_ready tied 1 -> grants alternate 0,1,0,1; one response every 3 cycles.
REQ-034 Req1 op 001, A=0x05, B=0x05 -> rsp_y 0x00, rsp_z 1, rsp_c 0; then A=0x03, B=0x05 -> rsp_y 0xFE, rsp_c 1.
REQ-035 Op 110 A=0x81 -> rsp_y 0x02, rsp_c 1; op 111 A=0x81 -> rsp_y 0x40, rsp_c 1; op 101 A=0xFF -> rsp_y 0x00, rsp_z 1.
REQ-036 rsp_ready held 0 for 5 cycles in RESP -> outputs stable, req_ready 0 throughout; rsp_ready 1 -> IDLE next edge.
REQ-037 rst_n asserted mid-EXEC -> rsp_valid 0 and outputs 0 immediately; after release, no stale response; both valid -> requester 0 granted first.
